// File: rtl/uart_cmd_pkg.sv
// Shared types and framing constants for the UART command front end.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, LSB first, one-cycle tx_done after the stop bit.
//
// state    | meaning
// TX_IDLE  | line idle high, waiting for trmt
// TX_SHIFT | shifting start/data/stop bits, each held BAUD_DIV cycles
module uart_tx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int              BW        = $clog2(BAUD_DIV) + 1;
    localparam logic [BW-1:0]   BAUD_FULL = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]   ONE       = BW'(1);

    tx_state_t       r_state;
    tx_state_t       w_next;
    logic [9:0]      r_shift;
    logic [BW-1:0]   r_baud;
    logic [3:0]      r_bits;
    logic            r_done;
    logic            w_tc;
    logic            w_load;
    logic            w_shift;
    logic            w_last;

    assign w_tc = (r_baud == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= TX_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: a request is only honoured while idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            TX_IDLE:  if (trmt) w_next = TX_SHIFT;
            TX_SHIFT: if (w_tc && r_bits == 4'd9) w_next = TX_IDLE;
            default:  w_next = TX_IDLE;
        endcase
    end

    // Datapath strobes decoded from the state.
    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            TX_IDLE:  w_load  = trmt;
            TX_SHIFT: w_shift = w_tc;
            default:  ;
        endcase
        w_last = w_shift && (r_bits == 4'd9);
    end

    // Shifter, baud down-counter and bit counter; shifter resets to all ones so TX idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '1;
            r_baud  <= '0;
            r_bits  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_shift <= {STOP_BIT, tx_data, START_BIT};
                r_baud  <= BAUD_FULL;
                r_bits  <= '0;
            end else if (w_shift) begin
                r_shift <= {STOP_BIT, r_shift[9:1]};
                if (w_last) begin
                    r_baud <= '0;
                end else begin
                    r_baud <= BAUD_FULL;
                    r_bits <= r_bits + 4'd1;
                end
            end else if (!w_tc) begin
                r_baud <= r_baud - ONE;
            end
        end
    end

    assign TX      = r_shift[0];
    assign tx_done = r_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host serial front end: UART RX assembles byte pairs into 16-bit commands,
// UART TX returns 8-bit responses.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, then confirm the start bit
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling the stop bit; good stop yields a byte
// WAIT_HI  | no byte held, next byte is the command high byte
// WAIT_LO  | high byte held, waiting for low byte or timeout
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int TO_BITS  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        cmd_ovr
);
    localparam int              BW        = $clog2(BAUD_DIV) + 1;
    localparam int              TW        = $clog2(TO_BITS) + 1;
    localparam logic [BW-1:0]   BAUD_FULL = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]   BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0]   ONE_B     = BW'(1);
    localparam logic [TW-1:0]   TO_LIMIT  = TW'(TO_BITS);
    localparam logic [TW-1:0]   ONE_T     = TW'(1);

    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    logic            w_rx_fall;
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [BW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bits;
    logic [7:0]      r_rx_shift;
    logic            r_byte_rdy;
    logic            w_rx_tc;
    logic            w_rx_load_half;
    logic            w_rx_load_full;
    logic            w_rx_sample;
    logic            w_rx_stop_ok;

    asm_state_t      r_asm_state;
    asm_state_t      w_asm_next;
    logic [7:0]      r_hi_byte;
    logic [BW-1:0]   r_to_div;
    logic [TW-1:0]   r_to_cnt;
    logic            w_to_expired;
    logic            w_hi_load;
    logic            w_pair_done;
    logic            w_to_run;

    logic [15:0]     r_cmd;
    logic            r_cmd_rdy;
    logic            r_cmd_ovr;

    // Two-flop synchronizer plus edge-detect history, all preset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_tc   = (r_rx_cnt == '0);

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // RX next-state; start edges are only looked for in RX_IDLE.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_tc) w_rx_next = (r_rx_s2 == START_BIT) ? RX_DATA : RX_IDLE;
            RX_DATA:  if (w_rx_tc && r_rx_bits == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tc) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX datapath strobes decoded from the state.
    always_comb begin
        w_rx_load_half = 1'b0;
        w_rx_load_full = 1'b0;
        w_rx_sample    = 1'b0;
        w_rx_stop_ok   = 1'b0;
        case (r_rx_state)
            RX_IDLE:  w_rx_load_half = w_rx_fall;
            RX_START: w_rx_load_full = w_rx_tc;
            RX_DATA: begin
                w_rx_sample    = w_rx_tc;
                w_rx_load_full = w_rx_tc;
            end
            RX_STOP:  w_rx_stop_ok = w_rx_tc && (r_rx_s2 == STOP_BIT);
            default:  ;
        endcase
    end

    // RX sample timer, bit counter, shift register and byte-ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_byte_rdy <= 1'b0;
        end else begin
            r_byte_rdy <= w_rx_stop_ok;
            if (w_rx_load_half)      r_rx_cnt <= BAUD_HALF;
            else if (w_rx_load_full) r_rx_cnt <= BAUD_FULL;
            else if (!w_rx_tc)       r_rx_cnt <= r_rx_cnt - ONE_B;
            if (r_rx_state == RX_START)               r_rx_bits <= '0;
            else if (w_rx_sample && r_rx_bits != 3'd7) r_rx_bits <= r_rx_bits + 3'd1;
            if (w_rx_sample) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        end
    end

    assign w_to_expired = (r_to_cnt == TO_LIMIT);

    // Assembler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_asm_state <= WAIT_HI;
        else        r_asm_state <= w_asm_next;
    end

    // Assembler next-state; a byte arriving on the timeout cycle still completes the pair.
    always_comb begin
        w_asm_next = r_asm_state;
        case (r_asm_state)
            WAIT_HI: if (r_byte_rdy) w_asm_next = WAIT_LO;
            WAIT_LO: if (r_byte_rdy || w_to_expired) w_asm_next = WAIT_HI;
            default: w_asm_next = WAIT_HI;
        endcase
    end

    // Assembler strobes; the timeout only advances while the receiver is idle.
    always_comb begin
        w_hi_load   = (r_asm_state == WAIT_HI) && r_byte_rdy;
        w_pair_done = (r_asm_state == WAIT_LO) && r_byte_rdy;
        w_to_run    = (r_asm_state == WAIT_LO) && (r_rx_state == RX_IDLE) && !w_to_expired;
    end

    // High-byte latch and inter-byte timeout (bit-period prescaler feeding a saturating count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_byte <= '0;
            r_to_div  <= '0;
            r_to_cnt  <= '0;
        end else if (w_hi_load) begin
            r_hi_byte <= r_rx_shift;
            r_to_div  <= BAUD_FULL;
            r_to_cnt  <= '0;
        end else if (w_to_run) begin
            if (r_to_div == '0) begin
                r_to_div <= BAUD_FULL;
                r_to_cnt <= r_to_cnt + ONE_T;
            end else begin
                r_to_div <= r_to_div - ONE_B;
            end
        end
    end

    // Command register and handshake; a completing pair beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_cmd_ovr <= 1'b0;
        end else begin
            r_cmd_ovr <= w_pair_done && r_cmd_rdy && !clr_cmd_rdy;
            if (w_pair_done) begin
                r_cmd     <= {r_hi_byte, r_rx_shift};
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign cmd_ovr = r_cmd_ovr;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (send_resp),
        .tx_data (resp),
        .TX      (TX),
        .tx_done (resp_sent)
    );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper at BAUD_DIV=16, TO_BITS=64.
module tb_uart_cmd_wrapper;
    localparam int BD = 16;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        cmd_ovr;

    int n_pass  = 0;
    int n_total = 0;
    int ovr_cnt  = 0;
    int sent_cnt = 0;

    uart_cmd_wrapper #(
        .BAUD_DIV (BD),
        .TO_BITS  (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .cmd_ovr     (cmd_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for one-cycle outputs.
    always @(negedge clk) begin
        if (cmd_ovr === 1'b1)   ovr_cnt++;
        if (resp_sent === 1'b1) sent_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            tick(BD);
        end
    endtask

    // Sends a pair; samples cmd_rdy just before and just after the completion edge,
    // optionally asserting clr_cmd_rdy exactly on that edge.
    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input logic clr_hit,
                             output logic rdy_pre, output logic rdy_post, output logic ovr_post);
        logic l_pre, l_post, l_ovr;
        send_byte(hi, 1'b1);
        fork
            send_byte(lo, 1'b1);
            begin
                tick(155);
                l_pre       = cmd_rdy;
                clr_cmd_rdy = clr_hit;
                tick(1);
                clr_cmd_rdy = 1'b0;
                l_post      = cmd_rdy;
                l_ovr       = cmd_ovr;
            end
        join
        rdy_pre  = l_pre;
        rdy_post = l_post;
        ovr_post = l_ovr;
    endtask

    logic       pre, post, ovr;
    logic [9:0] tx_exp;

    initial begin
        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        #22;
        check("rst_tx", TX, 1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_resp_sent", resp_sent, 0);
        check("rst_cmd_ovr", cmd_ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);

        // Basic pair and clear.
        send_pair(8'h47, 8'h05, 1'b0, pre, post, ovr);
        check("a_rdy_pre", pre, 0);
        check("a_rdy_post", post, 1);
        check("a_cmd", cmd, 16'h4705);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("a_clr_rdy", cmd_rdy, 0);
        check("a_clr_cmd", cmd, 16'h4705);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("a_clr_noop", cmd_rdy, 0);

        // Lone high byte times out.
        send_byte(8'h47, 1'b1);
        tick(70 * BD);
        send_byte(8'h00, 1'b1);
        check("b_no_pair_rdy", cmd_rdy, 0);
        check("b_no_pair_cmd", cmd, 16'h4705);
        send_byte(8'h12, 1'b1);
        check("b_cmd", cmd, 16'h0012);
        check("b_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;

        // Overwrite of a pending command, then coincident clear.
        send_pair(8'h81, 8'h03, 1'b0, pre, post, ovr);
        check("c1_cmd", cmd, 16'h8103);
        check("c1_ovr", ovr, 0);
        send_pair(8'h40, 8'h02, 1'b0, pre, post, ovr);
        check("c2_rdy_pre", pre, 1);
        check("c2_rdy_post", post, 1);
        check("c2_ovr", ovr, 1);
        check("c2_cmd", cmd, 16'h4002);
        tick(2);
        check("c2_ovr_count", ovr_cnt, 1);
        send_pair(8'h12, 8'h34, 1'b1, pre, post, ovr);
        check("c3_rdy_post", post, 1);
        check("c3_ovr", ovr, 0);
        check("c3_cmd", cmd, 16'h1234);
        tick(2);
        check("c3_ovr_count", ovr_cnt, 1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;

        // Framing error and false start.
        send_byte(8'h55, 1'b0);
        RX = 1'b1;
        tick(2 * BD);
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(2 * BD);
        send_byte(8'h01, 1'b1);
        check("d_after_hi_rdy", cmd_rdy, 0);
        send_byte(8'h02, 1'b1);
        check("d_cmd", cmd, 16'h0102);
        check("d_rdy", cmd_rdy, 1);

        // Transmit 0xA5; second request mid-frame ignored; back-to-back request accepted.
        tx_exp    = 10'b1101001010;
        resp      = 8'hA5;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        for (int c = 0; c <= 161; c++) begin
            if (c < 160 && (c % 16) == 8) check($sformatf("e_tx_bit%0d", c / 16), TX, tx_exp[c / 16]);
            if (c == 79) begin
                send_resp = 1'b1;
                resp      = 8'h00;
            end
            if (c == 80) send_resp = 1'b0;
            if (c == 159) check("e_sent_early", resp_sent, 0);
            if (c == 160) begin
                check("e_sent", resp_sent, 1);
                check("e_tx_idle", TX, 1);
                send_resp = 1'b1;
                resp      = 8'h3D;
            end
            if (c == 161) begin
                check("e_sent_cleared", resp_sent, 0);
                check("e_tx_restart", TX, 0);
                send_resp = 1'b0;
            end
            if (c < 161) tick(1);
        end

        // Reset in the middle of an RX byte and a TX byte.
        RX = 1'b0;
        tick(23);
        check("f_tx_bit1", TX, 1);
        tick(17);
        check("f_tx_bit2", TX, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f_rst_tx", TX, 1);
        check("f_rst_rdy", cmd_rdy, 0);
        check("f_rst_cmd", cmd, 16'h0000);
        RX = 1'b1;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("f_tx_after", TX, 1);
        check("f_sent_count", sent_cnt, 1);
        send_pair(8'h00, 8'h00, 1'b0, pre, post, ovr);
        check("f_rdy_pre", pre, 0);
        check("f_rdy_post", post, 1);
        check("f_cmd", cmd, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Host-side serial front end for the logic analyzer command path. Receives bytes on the UART RX line and assembles each pair (high byte first) into a 16-bit command with a cmd_rdy/clr_cmd_rdy handshake toward the command/config unit. Serializes that unit's 8-bit responses onto TX and returns a one-cycle resp_sent. Sits directly upstream (cmd) and downstream (resp) of the command/config block.

Parameters:
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); bench uses 16; must be >= 8
TO_BITS, 64, inter-byte timeout in bit periods before a lone high byte is discarded

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
RX  input  1  serial in from host, asynchronous, idle high
TX  output  1  serial out to host, idle high
cmd  output  16  assembled command, {first byte, second byte}
cmd_rdy  output  1  cmd valid; held until cleared
clr_cmd_rdy  input  1  knocks down cmd_rdy
resp  input  8  response byte, sampled on send_resp
send_resp  input  1  one-cycle request to transmit resp
resp_sent  output  1  one-cycle pulse when the stop bit completes
cmd_ovr  output  1  one-cycle pulse when a new cmd overwrites one still pending

Behaviour:
- Reset: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, cmd_ovr=0; RX synchronizer flops preset to 1; all FSMs idle; counters 0.
- RX sync: two flops (RXs). Falling edge of RXs in RX_IDLE starts a frame.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_START: wait BAUD_DIV/2 (floor) cycles, then sample; sample 1 = false start -> RX_IDLE, nothing produced.
  - RX_DATA: 8 samples BAUD_DIV apart, LSB first, into a shift register.
  - RX_STOP: sample after BAUD_DIV; 1 -> internal byte_rdy pulse on the following cycle; 0 -> framing error, byte dropped, no effect on the assembler; return to RX_IDLE either way.
  - No new start edge is accepted before the stop sample.
- Assembler FSM states: WAIT_HI, WAIT_LO.
  - WAIT_HI + byte_rdy: latch hi_byte -> WAIT_LO; clear timeout counter.
  - WAIT_LO + byte_rdy: cmd <= {hi_byte, byte}; cmd_rdy <= 1 the next cycle; -> WAIT_HI.
  - WAIT_LO timeout: counts bit periods while RX_IDLE; reaching TO_BITS discards hi_byte and returns to WAIT_HI. A start edge freezes the count.
- cmd stability: cmd changes only on pair completion. Pending command + new pair completion: cmd overwritten, cmd_rdy stays 1, cmd_ovr pulses.
- Simultaneous clr_cmd_rdy and pair completion: set wins, cmd_rdy stays 1, no cmd_ovr. clr_cmd_rdy with cmd_rdy=0 is a no-op.
- TX FSM states: TX_IDLE, TX_SHIFT.
  - On send_resp in TX_IDLE: latch {1, resp, 0} into a 10-bit shifter; TX=0 the next cycle.
  - Each bit is held BAUD_DIV cycles, LSB first.
  - After the 10th bit period, resp_sent=1 for one cycle and the FSM returns to TX_IDLE. A new send_resp is accepted in that same cycle.
  - send_resp while in TX_SHIFT is ignored.
- Reset mid-frame: all state aborts; TX returns to 1 immediately (async).
- Counters: baud counter width clog2(BAUD_DIV)+1; timeout counter width clog2(TO_BITS)+1; counters saturate and never wrap.

Decomposition:
- Package uart_cmd_pkg: rx_state_t, asm_state_t, tx_state_t enums; localparams START_BIT=0, STOP_BIT=1.
- One sub-module: uart_tx (BAUD_DIV parameter; ports clk, rst_n, trmt, tx_data, TX, tx_done), instantiated with trmt=send_resp, tx_done=resp_sent.
- RX and the assembler stay inline.

Test Plan:
- BAUD_DIV=16. Send 0x47 then 0x05 -> cmd=0x4705, cmd_rdy=1 about 1 cycle after the 2nd stop sample; pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd holds 0x4705.
- Send 0x47, idle 70 bit periods, send 0x00, 0x12 -> cmd=0x0012; no command 0x4700 ever appears.
- Send 0x8103 without clearing, then 0x4002 -> cmd=0x4002, cmd_rdy stays 1, cmd_ovr one pulse; repeat with clr_cmd_rdy coincident with completion -> cmd_rdy=1, no cmd_ovr.
- Byte 0x55 with stop bit forced 0, followed by 0x01, 0x02 -> cmd=0x0102; 0x55 discarded. A 4-cycle low glitch on RX -> false start, no byte.
- resp=0xA5, send_resp -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; resp_sent at cycle 161; second send_resp at cycle 80 ignored.
- Assert rst_n low mid-RX-byte and mid-TX-byte -> TX=1 and cmd_rdy=0 at once; after release, a clean 0x0000 pair gives cmd=0x0000 with cmd_rdy=1.
